img_zoom_ctrl: RTL and testbench

Zoom controller that sits directly upstream of the row-mapping RAM stage in the OV5640→HDMI 1080P60 scaling path. It turns zoom-in/zoom-out button pulses into a clamped scale factor `fix_rate`, in unsigned 6.5 fixed point where 32 = 1.0×. It computes the inverse coefficient `rate_coe = floor(1024 / fix_rate)` with a serial restoring divider. It publishes both values as a single-cycle valid pulse aligned to a frame boundary, so the downstream row table is rebuilt only between frames.

---
 rtl/img_zoom_ctrl.sv | 152 +++++++++++++++
 tb/tb_img_zoom_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/img_zoom_ctrl.sv
// Zoom controller: turns zoom button pulses into a clamped 6.5 fixed-point scale
// and its inverse floor(1024/scale), published as a frame-aligned one-cycle update.
module img_zoom_ctrl #(
    parameter int RATE_INIT = 32,
    parameter int RATE_MIN  = 8,
    parameter int RATE_MAX  = 96,
    parameter int RATE_STEP = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_zoom_in,
    input  logic        i_zoom_out,
    input  logic        i_frame_start,
    output logic [10:0] o_fix_rate,
    output logic [10:0] o_rate_coe,
    output logic        o_rate_coe_vld,
    output logic        o_busy
);

    localparam logic [10:0] L_INIT     = 11'(RATE_INIT);
    localparam logic [10:0] L_MIN      = 11'(RATE_MIN);
    localparam logic [10:0] L_MAX      = 11'(RATE_MAX);
    localparam logic [10:0] L_STEP     = 11'(RATE_STEP);
    localparam logic [10:0] L_DIVIDEND = 11'd1024;
    localparam logic [3:0]  L_LAST_IT  = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_WAIT
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [10:0] r_target;
    logic [11:0] r_rem;
    logic [9:0]  r_quo;
    logic [3:0]  r_cnt;
    logic [10:0] r_coe;
    logic [10:0] r_fix_rate;
    logic [10:0] r_rate_coe;
    logic        r_vld;
    logic        r_busy;

    logic [10:0] w_cand;
    logic        w_load;
    logic        w_div_last;
    logic        w_publish;
    logic        w_bit;
    logic [11:0] w_shift;
    logic        w_ge;
    logic [11:0] w_rem_nxt;
    logic [10:0] w_quo_nxt;

    // Clamp is decided before the add/subtract so the result never wraps.
    always_comb begin
        w_cand = r_target;
        if (i_zoom_in && !i_zoom_out) begin
            w_cand = (r_target >= L_MAX - L_STEP) ? L_MAX : r_target + L_STEP;
        end else if (i_zoom_out && !i_zoom_in) begin
            w_cand = (r_target <= L_MIN + L_STEP) ? L_MIN : r_target - L_STEP;
        end
    end

    // One restoring-division step; a set remainder MSB means the shifted value overflows past any divisor.
    always_comb begin
        w_bit     = L_DIVIDEND[L_LAST_IT - r_cnt];
        w_shift   = {r_rem[10:0], w_bit};
        w_ge      = r_rem[11] || (w_shift >= {1'b0, r_target});
        w_rem_nxt = w_ge ? (w_shift - {1'b0, r_target}) : w_shift;
        w_quo_nxt = {r_quo, w_ge};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_DIV;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_div_last  = 1'b0;
        w_publish   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cand != r_target) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_DIV;
                end
            end
            S_DIV: begin
                if (r_cnt == L_LAST_IT) begin
                    w_div_last  = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_frame_start) begin
                    w_publish   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_target   <= L_INIT;
            r_rem      <= '0;
            r_quo      <= '0;
            r_cnt      <= '0;
            r_coe      <= '0;
            r_fix_rate <= '0;
            r_rate_coe <= '0;
            r_vld      <= 1'b0;
            r_busy     <= 1'b1;
        end else begin
            r_vld  <= w_publish;
            r_busy <= (w_state_nxt != S_IDLE);
            if (w_load) begin
                r_target <= w_cand;
                r_rem    <= '0;
                r_quo    <= '0;
                r_cnt    <= '0;
            end else if (r_state == S_DIV) begin
                r_rem <= w_rem_nxt;
                r_quo <= w_quo_nxt[9:0];
                r_cnt <= r_cnt + 4'd1;
                if (w_div_last) begin
                    r_coe <= w_quo_nxt;
                end
            end
            if (w_publish) begin
                r_fix_rate <= r_target;
                r_rate_coe <= r_coe;
            end
        end
    end

    assign o_fix_rate     = r_fix_rate;
    assign o_rate_coe     = r_rate_coe;
    assign o_rate_coe_vld = r_vld;
    assign o_busy         = r_busy;

endmodule

// File: tb/tb_img_zoom_ctrl.sv
// Directed bench for img_zoom_ctrl: expected updates are queued when stimulus is
// driven and compared whenever the DUT pulses o_rate_coe_vld.
module tb_img_zoom_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_zoom_in = 1'b0;
    logic        i_zoom_out = 1'b0;
    logic        i_frame_start = 1'b0;
    logic [10:0] o_fix_rate;
    logic [10:0] o_rate_coe;
    logic        o_rate_coe_vld;
    logic        o_busy;

    int          errors = 0;
    int          checks = 0;
    int          cur = 32;
    logic [21:0] sb[$];
    logic        prev_vld = 1'b0;

    img_zoom_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .i_zoom_in      (i_zoom_in),
        .i_zoom_out     (i_zoom_out),
        .i_frame_start  (i_frame_start),
        .o_fix_rate     (o_fix_rate),
        .o_rate_coe     (o_rate_coe),
        .o_rate_coe_vld (o_rate_coe_vld),
        .o_busy         (o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int v);
        sb.push_back({11'(v), 11'(1024 / v)});
    endtask

    // Scoreboard: every vld pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        logic [21:0] e;
        if (o_rate_coe_vld === 1'b1) begin
            chk("vld_single_cycle", 11'(prev_vld), 11'd0);
            if (sb.size() == 0) begin
                chk("vld_unexpected", 11'(o_rate_coe_vld), 11'd0);
            end else begin
                e = sb.pop_front();
                chk("upd_fix_rate", o_fix_rate, e[21:11]);
                chk("upd_rate_coe", o_rate_coe, e[10:0]);
            end
        end
        prev_vld = o_rate_coe_vld;
    end

    task automatic frame(input logic exp_vld, input logic exp_busy);
        i_frame_start = 1'b1;
        @(negedge clk);
        i_frame_start = 1'b0;
        chk("frame_vld", 11'(o_rate_coe_vld), 11'(exp_vld));
        chk("frame_busy", 11'(o_busy), 11'(exp_busy));
    endtask

    task automatic zoom(input logic zin, input logic zout);
        i_zoom_in  = zin;
        i_zoom_out = zout;
        @(negedge clk);
        i_zoom_in  = 1'b0;
        i_zoom_out = 1'b0;
    endtask

    task automatic step(input logic zin, input logic zout, input logic accept);
        zoom(zin, zout);
        chk("busy_after_zoom", 11'(o_busy), 11'(accept));
        if (accept) begin
            if (zin) cur = (cur + 2 > 96) ? 96 : cur + 2;
            else     cur = (cur - 2 < 8) ? 8 : cur - 2;
            push(cur);
            repeat (12) @(negedge clk);
            frame(1'b1, 1'b0);
        end else begin
            frame(1'b0, 1'b0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_fix_rate", o_fix_rate, 11'd0);
        chk("rst_rate_coe", o_rate_coe, 11'd0);
        chk("rst_vld", 11'(o_rate_coe_vld), 11'd0);
        chk("rst_busy", 11'(o_busy), 11'd1);
        rst = 1'b0;

        // Initial scale is published at the first frame start.
        repeat (20) @(negedge clk);
        cur = 32;
        push(32);
        frame(1'b1, 1'b0);

        // Frame start on the 11th divide cycle is ignored; the next one publishes.
        zoom(1'b1, 1'b0);
        chk("busy_div_start", 11'(o_busy), 11'd1);
        cur = 34;
        push(34);
        repeat (10) @(negedge clk);
        frame(1'b0, 1'b1);
        frame(1'b1, 1'b0);

        while (cur < 94) step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("at_max", o_fix_rate, 11'd96);
        step(1'b1, 1'b0, 1'b0);

        while (cur > 10) step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        chk("at_min_coe", o_rate_coe, 11'd128);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);

        while (cur < 32) step(1'b1, 1'b0, 1'b1);

        // Early frame start and a second zoom pulse while busy are both dropped.
        zoom(1'b1, 1'b0);
        chk("busy_early", 11'(o_busy), 11'd1);
        cur = 34;
        push(34);
        repeat (4) @(negedge clk);
        frame(1'b0, 1'b1);
        zoom(1'b1, 1'b0);
        chk("busy_drop", 11'(o_busy), 11'd1);
        repeat (12) @(negedge clk);
        frame(1'b1, 1'b0);
        chk("drop_final_fix", o_fix_rate, 11'd34);

        // Reset during a divide aborts it and restarts from the initial scale.
        step(1'b0, 1'b1, 1'b1);
        zoom(1'b1, 1'b0);
        chk("busy_pre_rst", 11'(o_busy), 11'd1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_fix", o_fix_rate, 11'd0);
        chk("mid_rst_vld", 11'(o_rate_coe_vld), 11'd0);
        chk("mid_rst_busy", 11'(o_busy), 11'd1);
        cur = 32;
        push(32);
        repeat (12) @(negedge clk);
        frame(1'b1, 1'b0);

        repeat (3) @(negedge clk);
        chk("sb_empty", 11'(sb.size()), 11'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
